mem_bank_ctrl: RTL and testbench

Parametrised single-port word memory with byte-lane write enables, one-cycle registered read, and a self-initialising fill engine that loads every word with its own byte addresses. A byte-select display register drives the board LEDs from the most recent read word. It is the generalised successor of the fixed 64-word memory experiment and sits between the switch and button inputs and the LED bank.

---
 rtl/mem_bank_pkg.sv | 21 ++
 rtl/mem_bank_ram.sv | 45 ++++
 rtl/mem_bank_ctrl.sv | 153 +++++++++++++++
 tb/tb_mem_bank_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mem_bank_pkg.sv
// Shared definitions for the byte-lane memory bank controller:
// FSM state encodings and the fill-pattern helper.
package mem_bank_pkg;

    // Controller states, kept as plain constants for legacy tool flows
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_IDLE = 1'b1;

    // Fill pattern: each byte holds the low 8 bits of its own byte address,
    // i.e. word_idx * lanes + lane.
    function automatic logic [7:0] init_byte(
        input logic [31:0] word_idx,
        input logic [31:0] lane,
        input logic [31:0] lanes
    );
        logic [31:0] w_byte_addr;
        w_byte_addr = (word_idx * lanes) + lane;
        return w_byte_addr[7:0];
    endfunction

endpackage

// File: rtl/mem_bank_ram.sv
// Single-port RAM with per-byte write enables and a registered, read-first
// synchronous read port. The array itself is never reset; only the read
// data register is cleared so the visible output starts at zero.
module mem_bank_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W/8-1:0]   i_we,
    input  logic                  i_re,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [DATA_W-1:0]     i_wdata,
    output logic [DATA_W-1:0]     o_rdata
);

    localparam int LANES = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Byte-lane write into the array; untouched lanes keep their contents
    always_ff @(posedge clk) begin
        for (int b = 0; b < LANES; b++) begin
            if (i_we[b]) begin
                r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    // Read register: samples the pre-write word, so a same-cycle write is not seen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end else begin
            r_rdata <= r_rdata;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_bank_ctrl.sv
// Memory bank controller: runs the self-initialising fill after reset or on
// request, arbitrates host reads/writes onto the RAM, generates the read-valid
// pulse and drives the LED bank from a byte of the last word read.
module mem_bank_ctrl
    import mem_bank_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    localparam int LANES = DATA_W / 8,
    localparam int SEL_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic [ADDR_W-1:0]   Mem_Addr,
    input  logic                Mem_Write,
    input  logic [LANES-1:0]    Byte_En,
    input  logic [DATA_W-1:0]   Mem_WData,
    input  logic                Mem_Read,
    input  logic                Init_Start,
    input  logic [SEL_W-1:0]    Sel,
    output logic [DATA_W-1:0]   Mem_RData,
    output logic                Mem_Valid,
    output logic                Busy,
    output logic [7:0]          LED
);

    localparam logic [ADDR_W-1:0] PTR_LAST  = '1;
    localparam logic [SEL_W:0]    LANES_CMP = (SEL_W + 1)'(LANES);

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic              r_busy;
    logic              r_valid;
    logic [DATA_W-1:0] r_disp;

    logic [DATA_W-1:0] w_init_word;
    logic [LANES-1:0]  w_ram_we;
    logic              w_ram_re;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_wdata;
    logic [DATA_W-1:0] w_ram_rdata;
    logic [SEL_W-1:0]  w_lane;
    logic [7:0]        w_led;

    // Fill word for the current pointer: every byte holds its own byte address
    always_comb begin
        w_init_word = '0;
        for (int b = 0; b < LANES; b++) begin
            w_init_word[8*b +: 8] = init_byte(32'(r_ptr), 32'(b), 32'(LANES));
        end
    end

    // RAM port mux: the fill engine owns the port in INIT; a restart request
    // in IDLE swallows any host access issued in the same cycle
    always_comb begin
        w_ram_we    = '0;
        w_ram_re    = 1'b0;
        w_ram_addr  = Mem_Addr;
        w_ram_wdata = Mem_WData;
        if (r_state == ST_INIT) begin
            w_ram_we    = '1;
            w_ram_addr  = r_ptr;
            w_ram_wdata = w_init_word;
        end else if (Init_Start) begin
            w_ram_we = '0;
            w_ram_re = 1'b0;
        end else begin
            w_ram_we = Mem_Write ? Byte_En : '0;
            w_ram_re = Mem_Read;
        end
    end

    mem_bank_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (Clk),
        .rst_n   (Rst_n),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    // Fill FSM, pointer, busy flag and read-valid pulse
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= ST_INIT;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_ram_re;
            case (r_state)
                ST_INIT: begin
                    r_ptr <= r_ptr + ADDR_W'(1);
                    if (r_ptr == PTR_LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_INIT;
                        r_busy  <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (Init_Start) begin
                        r_state <= ST_INIT;
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_ptr   <= r_ptr;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                    r_ptr   <= '0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    // Display register captures the read word on the cycle it is presented
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_disp <= '0;
        end else if (r_valid) begin
            r_disp <= w_ram_rdata;
        end else begin
            r_disp <= r_disp;
        end
    end

    // LED lane select; out-of-range selects fall back to lane 0
    always_comb begin
        w_lane = '0;
        if ({1'b0, Sel} < LANES_CMP) begin
            w_lane = Sel;
        end else begin
            w_lane = '0;
        end
        w_led = r_disp[{w_lane, 3'b000} +: 8];
    end

    assign Mem_RData = w_ram_rdata;
    assign Mem_Valid = r_valid;
    assign Busy      = r_busy;
    assign LED       = w_led;

endmodule

// File: tb/tb_mem_bank_ctrl.sv
// Scoreboard bench for mem_bank_ctrl at default parameters (32-bit, 64 words).
// Stimulus pushes expected read data; a negedge monitor pops on Mem_Valid.
module tb_mem_bank_ctrl;

    logic        Clk;
    logic        Rst_n;
    logic [5:0]  Mem_Addr;
    logic        Mem_Write;
    logic [3:0]  Byte_En;
    logic [31:0] Mem_WData;
    logic        Mem_Read;
    logic        Init_Start;
    logic [1:0]  Sel;
    logic [31:0] Mem_RData;
    logic        Mem_Valid;
    logic        Busy;
    logic [7:0]  LED;

    int          errors = 0;
    int          checks = 0;
    int          n;
    logic [31:0] exp_q [$];
    logic [31:0] exp_word;

    mem_bank_ctrl #(.DATA_W(32), .ADDR_W(6)) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Mem_Addr   (Mem_Addr),
        .Mem_Write  (Mem_Write),
        .Byte_En    (Byte_En),
        .Mem_WData  (Mem_WData),
        .Mem_Read   (Mem_Read),
        .Init_Start (Init_Start),
        .Sel        (Sel),
        .Mem_RData  (Mem_RData),
        .Mem_Valid  (Mem_Valid),
        .Busy       (Busy),
        .LED        (LED)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Expected fill word: byte b of word a is (4*a + b) mod 256
    function automatic logic [31:0] fill_word(input int a);
        logic [31:0] w;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = 8'(4 * a + b);
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_read(input logic [5:0] a, input logic [31:0] exp);
        Mem_Addr = a;
        Mem_Read = 1'b1;
        exp_q.push_back(exp);
        tick();
        Mem_Read = 1'b0;
    endtask

    task automatic do_write(input logic [5:0] a, input logic [3:0] be, input logic [31:0] d);
        Mem_Addr  = a;
        Byte_En   = be;
        Mem_WData = d;
        Mem_Write = 1'b1;
        tick();
        Mem_Write = 1'b0;
    endtask

    task automatic count_busy(input string name);
        n = 0;
        while (Busy && n < 200) begin
            tick();
            n++;
        end
        chk(name, 32'(n), 32'd64);
    endtask

    // Monitor: every Mem_Valid must match the oldest outstanding expectation
    always @(negedge Clk) begin
        if (Rst_n && Mem_Valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got data %h expected no valid", Mem_RData);
            end else begin
                exp_word = exp_q.pop_front();
                if (Mem_RData !== exp_word) begin
                    errors++;
                    $display("FAIL read_data: got %h expected %h", Mem_RData, exp_word);
                end
            end
        end
    end

    initial begin
        Rst_n = 1'b0; Mem_Addr = '0; Mem_Write = 1'b0; Byte_En = '0;
        Mem_WData = '0; Mem_Read = 1'b0; Init_Start = 1'b0; Sel = '0;
        #22;
        chk("reset_busy",  32'(Busy), 32'd1);
        chk("reset_valid", 32'(Mem_Valid), 32'd0);
        chk("reset_rdata", Mem_RData, 32'h0);
        chk("reset_led",   32'(LED), 32'h0);
        @(negedge Clk);
        Rst_n = 1'b1;
        count_busy("fill_latency");
        chk("led_before_read", 32'(LED), 32'h0);

        // Basic read of the fill pattern
        do_read(6'h05, 32'h17161514);
        tick();
        chk("valid_one_cycle", 32'(Mem_Valid), 32'd0);
        chk("rdata_hold", Mem_RData, 32'h17161514);

        // Partial write: lanes 0 and 2 replaced, lanes 1 and 3 keep 0xFD/0xFF
        do_write(6'h3F, 4'b0101, 32'hAABBCCDD);
        do_read(6'h3F, 32'hFFBBFDDD);
        do_write(6'h3F, 4'b0000, 32'h12345678);
        do_read(6'h3F, 32'hFFBBFDDD);

        // Display sweep after reading 0x0B0A0908
        do_read(6'h02, 32'h0B0A0908);
        tick();
        tick();
        for (int s = 0; s < 4; s++) begin
            Sel = 2'(s);
            #1;
            chk("led_sweep", 32'(LED), 32'(8'h08 + s));
        end
        Sel = 2'd0;

        // Same-cycle write and read: read-first, then new data
        Mem_Addr = 6'h02; Byte_En = 4'hF; Mem_WData = 32'h11223344;
        Mem_Write = 1'b1; Mem_Read = 1'b1;
        exp_q.push_back(32'h0B0A0908);
        tick();
        Mem_Write = 1'b0; Mem_Read = 1'b0;
        do_read(6'h02, 32'h11223344);
        tick();
        tick();
        chk("led_after_new_read", 32'(LED), 32'h44);

        // Restart fill; host accesses during it must be ignored
        do_write(6'h01, 4'hF, 32'hDEADBEEF);
        do_read(6'h01, 32'hDEADBEEF);
        Init_Start = 1'b1; Mem_Read = 1'b1; Mem_Write = 1'b1;
        Mem_Addr = 6'h01; Byte_En = 4'hF; Mem_WData = 32'hCAFEF00D;
        tick();
        Init_Start = 1'b0;
        chk("restart_busy", 32'(Busy), 32'd1);
        count_busy("restart_latency");
        Mem_Read = 1'b0; Mem_Write = 1'b0;
        do_read(6'h01, 32'h07060504);
        do_read(6'h02, 32'h0B0A0908);
        tick();
        tick();

        // Reset in the middle of a fill
        Rst_n = 1'b0;
        #1;
        Rst_n = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("busy_mid_fill", 32'(Busy), 32'd1);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("midreset_rdata", Mem_RData, 32'h0);
        chk("midreset_led",   32'(LED), 32'h0);
        chk("midreset_busy",  32'(Busy), 32'd1);
        @(negedge Clk);
        Rst_n = 1'b1;
        count_busy("refill_latency");
        for (int a = 0; a < 64; a++) do_read(6'(a), fill_word(a));
        tick();
        tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
